// File: rtl/mailbox_responder_pkg.sv
// Shared constants and payload types for the mailbox responder.
// Holds the register map, the STATUS word layout and the CONTROL bit positions.
package mailbox_responder_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned OFFS_W = 2;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned BYTE_W = 8;

  // Word offsets decoded from CPU address[3:2]
  typedef enum logic [OFFS_W-1:0] {
    MBOX_DATA    = 2'd0,
    MBOX_STATUS  = 2'd1,
    MBOX_CONTROL = 2'd2,
    MBOX_RSVD    = 2'd3
  } mbox_reg_e;

  // CONTROL write bits
  localparam int unsigned CTRL_CLR_OVF  = 0;
  localparam int unsigned CTRL_FLUSH_RX = 1;
  localparam int unsigned CTRL_FLUSH_TX = 2;

  // STATUS read word, MSB first
  typedef struct packed {
    logic [7:0] rsvd_hi;
    logic [7:0] tx_count;
    logic [7:0] rx_count;
    logic [1:0] rsvd_lo;
    logic       tx_overflow;
    logic       rx_overflow;
    logic       tx_full;
    logic       tx_empty;
    logic       rx_full;
    logic       rx_empty;
  } mbox_status_t;

endpackage

// File: rtl/mailbox_responder_if.sv
// CPU word-bus connection between the core (master) and the mailbox (slave).
// Signals: select, address, bus_data_in, data_strobes, read, write from the
// master; bus_data_out and bus_error back from the slave.
interface mailbox_responder_if;
  import mailbox_responder_pkg::*;

  logic              select;
  logic [OFFS_W-1:0] address;
  logic [WORD_W-1:0] bus_data_in;
  logic [WORD_W-1:0] bus_data_out;
  logic [STRB_W-1:0] data_strobes;
  logic              read;
  logic              write;
  logic              bus_error;

  modport master (
    output select, address, bus_data_in, data_strobes, read, write,
    input  bus_data_out, bus_error
  );

  modport slave (
    input  select, address, bus_data_in, data_strobes, read, write,
    output bus_data_out, bus_error
  );

endinterface

// File: rtl/sync_byte_fifo.sv
// Single-clock byte FIFO with flush.
// Ports: clock, reset (async active-low); push_i/pop_i/flush_i requests;
// data_i write byte; data_o head byte; full_o, empty_o, count_o occupancy.
// Push is ignored when full, pop when empty; flush overrides both.
module sync_byte_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic                  flush_i,
  input  logic [7:0]            data_i,
  output logic [7:0]            data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   count_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // Pointer/count next state; pointers wrap naturally at DEPTH
  always_comb begin
    push_ok  = push_i & ~full_o & ~flush_i;
    pop_ok   = pop_i & ~empty_o & ~flush_i;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; stale entries are never visible through empty_o
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/mailbox_responder.sv
// Zero-wait-state bus target exposing a CPU-writable TX byte FIFO and a
// CPU-readable RX byte FIFO.
// Ports: clock, reset (async active-low); bus (slave side of the CPU word
// bus, bus_data_out and bus_error combinational); rx_data/rx_valid/rx_ready
// from the external producer; tx_data/tx_valid/tx_ready to the consumer.
module mailbox_responder
  import mailbox_responder_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  mailbox_responder_if.slave   bus,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready
);

  logic [7:0]          rx_head, tx_head;
  logic                rx_full, rx_empty, tx_full, tx_empty;
  logic [DEPTH_LOG2:0] rx_count, tx_count;

  logic      rx_ovf_q, rx_ovf_d, tx_ovf_q, tx_ovf_d;
  mbox_reg_e reg_sel;
  logic      access, illegal, rd_ok, wr_ok, ctrl_wr;
  logic      rx_pop, tx_push_req, clr_ovf, rx_flush, tx_flush;
  logic      rx_ovf_evt, tx_ovf_evt;
  mbox_status_t status;
  logic      unused_bus_bits;

  assign reg_sel         = mbox_reg_e'(bus.address);
  assign unused_bus_bits = ^{bus.bus_data_in[WORD_W-1:BYTE_W], bus.data_strobes[STRB_W-1:1]};

  // Access decode; an illegal access suppresses every bus side effect
  always_comb begin
    access  = bus.select & (bus.read | bus.write);
    illegal = (bus.read & bus.write)
            | (reg_sel == MBOX_RSVD)
            | (bus.write & (reg_sel == MBOX_STATUS))
            | (bus.write & ~bus.data_strobes[0]);
    bus.bus_error = access & illegal;
    rd_ok   = bus.select & bus.read  & ~bus.bus_error;
    wr_ok   = bus.select & bus.write & ~bus.bus_error;
    ctrl_wr = wr_ok & (reg_sel == MBOX_CONTROL);

    rx_pop      = rd_ok & (reg_sel == MBOX_DATA) & ~rx_empty;
    tx_push_req = wr_ok & (reg_sel == MBOX_DATA);
    clr_ovf     = ctrl_wr & bus.bus_data_in[CTRL_CLR_OVF];
    rx_flush    = ctrl_wr & bus.bus_data_in[CTRL_FLUSH_RX];
    tx_flush    = ctrl_wr & bus.bus_data_in[CTRL_FLUSH_TX];

    // Flush swallows the concurrent push without counting it as overflow
    rx_ovf_evt = rx_valid & rx_full & ~rx_flush;
    tx_ovf_evt = tx_push_req & tx_full & ~tx_flush;
    // A new event wins over a same-cycle clear
    rx_ovf_d = (rx_ovf_q & ~clr_ovf) | rx_ovf_evt;
    tx_ovf_d = (tx_ovf_q & ~clr_ovf) | tx_ovf_evt;
  end

  // STATUS word and read-data mux
  always_comb begin
    status             = '0;
    status.rx_empty    = rx_empty;
    status.rx_full     = rx_full;
    status.tx_empty    = tx_empty;
    status.tx_full     = tx_full;
    status.rx_overflow = rx_ovf_q;
    status.tx_overflow = tx_ovf_q;
    status.rx_count    = 8'(rx_count);
    status.tx_count    = 8'(tx_count);

    bus.bus_data_out = '0;
    if (rd_ok) begin
      case (reg_sel)
        MBOX_DATA:   if (!rx_empty) bus.bus_data_out = {1'b1, 23'b0, rx_head};
        MBOX_STATUS: bus.bus_data_out = status;
        default:     bus.bus_data_out = '0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_ovf_q <= 1'b0;
      tx_ovf_q <= 1'b0;
    end else begin
      rx_ovf_q <= rx_ovf_d;
      tx_ovf_q <= tx_ovf_d;
    end
  end

  assign rx_ready = ~rx_full;
  assign tx_valid = ~tx_empty;
  assign tx_data  = tx_valid ? tx_head : 8'h00;

  sync_byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (rx_valid & rx_ready),
    .pop_i   (rx_pop),
    .flush_i (rx_flush),
    .data_i  (rx_data),
    .data_o  (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_count)
  );

  sync_byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (tx_push_req),
    .pop_i   (tx_valid & tx_ready),
    .flush_i (tx_flush),
    .data_i  (bus.bus_data_in[7:0]),
    .data_o  (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count)
  );

endmodule

// File: tb/tb_mailbox_responder.sv
// Self-checking bench for mailbox_responder: queue-based model checked every
// cycle, plus directed vectors with hand-computed literal expectations.
module tb_mailbox_responder;

  localparam int unsigned D = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;

  mailbox_responder_if bus();

  mailbox_responder #(.DEPTH_LOG2(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  logic m_rx_ovf = 1'b0;
  logic m_tx_ovf = 1'b0;

  function automatic logic model_err();
    logic acc;
    acc = bus.select && (bus.read || bus.write);
    return acc && ((bus.read && bus.write) || bus.address == 2'd3 ||
                   (bus.write && bus.address == 2'd1) ||
                   (bus.write && !bus.data_strobes[0]));
  endfunction

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s = 32'h0;
    s[0] = (rxq.size() == 0);
    s[1] = (rxq.size() == D);
    s[2] = (txq.size() == 0);
    s[3] = (txq.size() == D);
    s[4] = m_rx_ovf;
    s[5] = m_tx_ovf;
    s[15:8]  = 8'(rxq.size());
    s[23:16] = 8'(txq.size());
    return s;
  endfunction

  function automatic logic [31:0] model_rdata();
    if (!(bus.select && bus.read) || model_err()) return 32'h0;
    if (bus.address == 2'd0) return (rxq.size() > 0) ? {24'h800000, rxq[0]} : 32'h0;
    if (bus.address == 2'd1) return model_status();
    return 32'h0;
  endfunction

  bit m_ok, m_rx_full0, m_tx_full0, m_rx_evt, m_tx_evt, m_ctrl, m_clr;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      rxq.delete();
      txq.delete();
      m_rx_ovf = 1'b0;
      m_tx_ovf = 1'b0;
    end else begin
      m_ok       = !model_err();
      m_rx_full0 = (rxq.size() == D);
      m_tx_full0 = (txq.size() == D);
      m_rx_evt   = 1'b0;
      m_tx_evt   = 1'b0;
      m_ctrl     = m_ok && bus.select && bus.write && bus.address == 2'd2;
      m_clr      = m_ctrl && bus.bus_data_in[0];
      if (m_ctrl && bus.bus_data_in[1]) rxq.delete();
      else begin
        if (m_ok && bus.select && bus.read && bus.address == 2'd0 && rxq.size() > 0)
          void'(rxq.pop_front());
        if (rx_valid) begin
          if (!m_rx_full0) rxq.push_back(rx_data);
          else m_rx_evt = 1'b1;
        end
      end
      if (m_ctrl && bus.bus_data_in[2]) txq.delete();
      else begin
        if (tx_ready && txq.size() > 0) void'(txq.pop_front());
        if (m_ok && bus.select && bus.write && bus.address == 2'd0) begin
          if (!m_tx_full0) txq.push_back(bus.bus_data_in[7:0]);
          else m_tx_evt = 1'b1;
        end
      end
      if (m_clr) begin m_rx_ovf = 1'b0; m_tx_ovf = 1'b0; end
      if (m_rx_evt) m_rx_ovf = 1'b1;
      if (m_tx_evt) m_tx_ovf = 1'b1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clock) begin
    if (chk_en) begin
      chk("bus_data_out", bus.bus_data_out, model_rdata());
      chk("bus_error", 32'(bus.bus_error), 32'(model_err()));
      chk("rx_ready", 32'(rx_ready), 32'(rxq.size() < D));
      chk("tx_valid", 32'(tx_valid), 32'(txq.size() > 0));
      chk("tx_data", 32'(tx_data), 32'((txq.size() > 0) ? txq[0] : 8'h00));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic bus_set(input logic rd, input logic wr, input logic [1:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    bus.select = 1'b1; bus.read = rd; bus.write = wr;
    bus.address = a; bus.bus_data_in = d; bus.data_strobes = s;
  endtask

  task automatic bus_idle();
    bus.select = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
    bus.address = 2'd0; bus.bus_data_in = 32'h0; bus.data_strobes = 4'h0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_read(input logic [1:0] a, input logic [31:0] exp, input string name);
    bus_set(1'b1, 1'b0, a, 32'h0, 4'hf);
    @(negedge clock);
    chk(name, bus.bus_data_out, exp);
    tick();
    bus_idle();
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
    bus_set(1'b0, 1'b1, a, d, s);
    tick();
    bus_idle();
  endtask

  task automatic do_err(input logic rd, input logic wr, input logic [1:0] a,
                        input logic [31:0] d, input logic [3:0] s, input string name);
    bus_set(rd, wr, a, d, s);
    @(negedge clock);
    chk(name, 32'(bus.bus_error), 32'h1);
    chk({name, "_rdata"}, bus.bus_data_out, 32'h0);
    tick();
    bus_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_idle();
    #2 reset = 1'b0;
    chk_en = 1'b1;
    tick(); tick();
    reset = 1'b1;
    tick();

    // Reset state
    do_read(2'd1, 32'h0000_0005, "reset_status");
    chk("reset_rx_ready", 32'(rx_ready), 32'h1);
    chk("reset_tx_valid", 32'(tx_valid), 32'h0);

    // Producer pushes two bytes, CPU reads them back
    rx_valid = 1'b1; rx_data = 8'h41; tick();
    rx_data = 8'h42; tick();
    rx_valid = 1'b0;
    do_read(2'd0, 32'h8000_0041, "rx_read0");
    do_read(2'd0, 32'h8000_0042, "rx_read1");
    do_read(2'd0, 32'h0000_0000, "rx_read_empty");
    do_read(2'd1, 32'h0000_0005, "rx_status_empty");

    // 17 CPU writes with no consumer: full plus overflow
    for (int i = 0; i < 17; i++) begin
      bus_set(1'b0, 1'b1, 2'd0, 32'hFFFF_FF00 | 32'(8'h10 + i), 4'h1);
      @(negedge clock);
      if (i == 1) begin
        chk("tx_first_valid", 32'(tx_valid), 32'h1);
        chk("tx_first_data", 32'(tx_data), 32'h10);
      end
      tick();
      bus_idle();
    end
    do_read(2'd1, 32'h0010_0029, "tx_full_status");
    do_write(2'd2, 32'h1, 4'hf);
    do_read(2'd1, 32'h0010_0009, "tx_ovf_cleared");

    // Drain in order
    tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      chk("tx_drain_data", 32'(tx_data), 32'(8'h10 + i));
      tick();
    end
    tx_ready = 1'b0;
    @(negedge clock);
    chk("tx_drained", 32'(tx_valid), 32'h0);
    tick();

    // Fill RX, then read while producer still pushing into a full FIFO
    rx_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rx_data = 8'(8'h60 + i);
      tick();
    end
    rx_data = 8'h99;
    bus_set(1'b1, 1'b0, 2'd0, 32'h0, 4'hf);
    @(negedge clock);
    chk("rx_full_ready", 32'(rx_ready), 32'h0);
    chk("rx_full_read", bus.bus_data_out, 32'h8000_0060);
    tick();
    bus_idle();
    rx_valid = 1'b0;
    do_read(2'd1, 32'h0000_0F14, "rx_ovf_status");

    // Illegal accesses: error and no side effects
    do_err(1'b0, 1'b1, 2'd1, 32'hFFFF_FFFF, 4'hf, "err_wr_status");
    do_err(1'b1, 1'b0, 2'd3, 32'h0, 4'hf, "err_rd_off3");
    do_err(1'b0, 1'b1, 2'd3, 32'h7, 4'hf, "err_wr_off3");
    do_err(1'b0, 1'b1, 2'd0, 32'h55, 4'b1110, "err_data_strobe");
    do_err(1'b0, 1'b1, 2'd2, 32'h7, 4'b1110, "err_ctrl_strobe");
    do_err(1'b1, 1'b1, 2'd0, 32'h0, 4'hf, "err_rd_and_wr");
    do_read(2'd2, 32'h0000_0000, "ctrl_read_zero");
    do_read(2'd1, 32'h0000_0F14, "err_no_effect");

    // Flush both FIFOs while producer is pushing
    do_write(2'd0, 32'hA1, 4'h1);
    do_write(2'd0, 32'hA2, 4'h1);
    do_write(2'd0, 32'hA3, 4'h1);
    rx_valid = 1'b1; rx_data = 8'h77;
    do_write(2'd2, 32'h6, 4'hf);
    rx_valid = 1'b0;
    do_read(2'd1, 32'h0000_0015, "flush_status");

    // Clear in the same cycle as a new overflow keeps the flag
    rx_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rx_data = 8'(8'h30 + i);
      tick();
    end
    do_write(2'd2, 32'h1, 4'hf);
    rx_valid = 1'b0;
    do_read(2'd1, 32'h0000_1016, "clr_vs_ovf");
    do_write(2'd2, 32'h3, 4'hf);
    do_read(2'd1, 32'h0000_0005, "clr_flush_rx");

    // Reset during a drain
    for (int i = 0; i < 4; i++) do_write(2'd0, 32'(8'hC0 + i), 4'h1);
    tx_ready = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("async_reset_tx_valid", 32'(tx_valid), 32'h0);
    chk("async_reset_rx_ready", 32'(rx_ready), 32'h1);
    tick();
    reset = 1'b1;
    tx_ready = 1'b0;
    tick();
    do_read(2'd1, 32'h0000_0005, "post_reset_status");

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mailbox_responder.md
Name: mailbox_responder

Overview:
Memory-mapped bus target (responder) for the core's 32-bit word bus. It is the far end of the core's address/read/write/strobe/bus_error interface. Presents a CPU-writable TX byte FIFO, drained by an external consumer, and a CPU-readable RX byte FIFO, filled by an external producer; both external sides use valid/ready. Sits behind the system address decoder, which supplies `select`. The bus has no wait states, so all reads complete in the same cycle.

Parameters:
DEPTH_LOG2, 4, log2 of each FIFO depth (16 entries); legal range 1..7.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
select  in  1  address decoder hit for this block
address  in  2  word offset (CPU address[3:2])
bus_data_in  in  32  write data from CPU (CPU data_out)
bus_data_out  out  32  read data to CPU; 0 when not (select & read)
data_strobes  in  4  byte lanes; strobe[0] = bits 7:0
read  in  1  CPU read cycle
write  in  1  CPU write cycle
bus_error  out  1  combinational; illegal access this cycle
rx_data  in  8  external producer byte
rx_valid  in  1  producer has byte
rx_ready  out  1  = !rx_full
tx_data  out  8  TX FIFO head
tx_valid  out  1  = !tx_empty
tx_ready  in  1  consumer takes byte

Behaviour:
- Register map (word offsets), all constants in the shared header:
  - 0 DATA. Read: returns {rx_nonempty at bit31, 23'b0, rx_head[7:0]} combinationally, and pops RX at the clock edge if non-empty; a read when empty returns 0 and does not pop. Write: pushes bus_data_in[7:0] into TX.
  - 1 STATUS, read-only. bit0 rx_empty, bit1 rx_full, bit2 tx_empty, bit3 tx_full, bit4 rx_overflow, bit5 tx_overflow, [15:8] rx_count, [23:16] tx_count, all other bits 0. A write raises bus_error and has no effect.
  - 2 CONTROL, write-only. bit0 clear both overflow flags, bit1 flush RX, bit2 flush TX. Reads return 0.
  - 3: any access raises bus_error; reads return 0.
- bus_error is asserted when select & (read|write) and one of:
  - offset 3;
  - write to STATUS;
  - DATA or CONTROL write with strobe[0]=0.
  When bus_error is asserted there are no side effects that cycle. read & write together is also bus_error.
- Transfers:
  - External RX push when rx_valid & rx_ready.
  - TX pop when tx_valid & tx_ready.
  - rx_valid while full: no push; rx_overflow sets (sticky).
  - CPU DATA write while TX full: byte dropped; tx_overflow sets (sticky).
- Same-cycle events:
  - Push and pop in the same cycle on one FIFO: both occur, count unchanged. Ready is based only on the current full state; it is never recomputed from a same-cycle pop.
  - Flush has priority over push/pop on that FIFO: pointers and count go to 0, a concurrent push is discarded, and no overflow is recorded.
  - Clearing overflow in the same cycle as a new overflow event leaves the flag set.
- Pointers are DEPTH_LOG2 bits and wrap modulo depth. Counts are DEPTH_LOG2+1 bits, zero-extended into the 8-bit status fields.
- Reset (asynchronous assert, synchronous release on clock) sets:
  - pointers and counts 0, overflow flags 0;
  - rx_ready=1, tx_valid=0, tx_data=0, bus_data_out=0, bus_error=0.
  - Reset during a transfer abandons it; FIFO contents are undefined but unobservable.
- Latency: a CPU-written byte appears on tx_valid/tx_data the cycle after the write edge; an external byte is visible to a DATA read the cycle after the push edge.

Decomposition:
- Shared header mailbox.vh: register offsets (MBOX_DATA=0, MBOX_STATUS=1, MBOX_CONTROL=2), STATUS bit positions and field ranges, CONTROL bit positions.
- One sub-module, sync_byte_fifo (parameter DEPTH_LOG2; push, pop, flush, data in/out, full, empty, count), instanced twice for RX and TX. Register decode, bus_error and overflow flags stay in the top module.

Test Plan:
- Reset → STATUS reads 0x00000005; rx_ready=1, tx_valid=0.
- Producer pushes 0x41,0x42; two DATA reads → 0x80000041, 0x80000042; a third read → 0x00000000; STATUS rx_count=0.
- CPU writes 17 bytes to DATA with tx_ready=0 → STATUS tx_full=1, tx_count=16, tx_overflow=1. Then CONTROL write 0x1 → tx_overflow=0. Then assert tx_ready → 16 bytes drain in order, first byte on the cycle after the first write.
- RX full plus a DATA read and rx_valid in the same cycle → pop occurs, no push (rx_ready=0), rx_overflow=1, rx_count=15.
- Write to STATUS; access to offset 3; DATA write with strobes=4'b1110 → bus_error=1 each cycle and no state change.
- CONTROL write 0x6 while both FIFOs hold data and rx_valid is high → both counts 0 the next cycle, no overflow set; assert reset mid-drain → tx_valid=0 immediately.
